// File: rtl/vga_sync_monitor.sv
// VGA input-side timing checker: measures hsync/vsync timing against one video format,
// tracks lock, and accumulates a per-frame pixel count and modulo-2^32 RGB checksum.
module vga_sync_monitor #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FRONT  = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BACK   = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FRONT  = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BACK   = 23,
    parameter int   CPP      = 2,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        locked,
    output logic        frame_done,
    output logic        timing_err,
    output logic [7:0]  err_cnt,
    output logic [15:0] h_period,
    output logic [15:0] h_width,
    output logic [11:0] v_lines,
    output logic [11:0] v_width,
    output logic [19:0] pix_cnt,
    output logic [31:0] frame_sum
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [15:0] H_PER_EXP = 16'(H_TOTAL * CPP);
    localparam logic [15:0] H_SW_EXP  = 16'(H_SYNC * CPP);
    localparam logic [15:0] H_ACT_LO  = 16'((H_SYNC + H_BACK) * CPP);
    localparam logic [15:0] H_ACT_HI  = 16'((H_SYNC + H_BACK + H_ACTIVE) * CPP);
    localparam logic [15:0] CPP_W     = 16'(CPP);
    localparam logic [15:0] TO_LAST   = 16'(2 * H_TOTAL * CPP - 1);
    localparam logic [11:0] V_ACT_LO  = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_ACT_HI  = 12'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [11:0] V_TOT_EXP = 12'(V_TOTAL);
    localparam logic [11:0] V_SW_EXP  = 12'(V_SYNC);
    localparam logic [19:0] PIX_EXP   = 20'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic        hs_p1, vs_p1, hs_p2, vs_p2;
    logic [11:0] rgb_p1, rgb_p2;

    logic [15:0] hclk, hw_cnt;
    logic [11:0] line, hedge_cnt, vw_cnt;
    logic [19:0] pix_acc;
    logic [31:0] sum_acc;

    state_t      state;
    logic        mis_flag, skip_chk;

    logic        h_lead, h_trail, v_lead;
    logic        pix_act, line_bad, line_mis_now, frame_ok, timeout;
    logic [15:0] h_per_now;

    // Stage p1: register and normalise syncs; stage p2: second delay for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_p1 <= 1'b0;
            vs_p1 <= 1'b0;
            hs_p2 <= 1'b0;
            vs_p2 <= 1'b0;
        end else begin
            hs_p1 <= (hsync == SYNC_POL);
            vs_p1 <= (vsync == SYNC_POL);
            hs_p2 <= hs_p1;
            vs_p2 <= vs_p1;
        end
    end

    // Colour is delayed twice so that hclk == k lines up with clock k of the line
    always_ff @(posedge clk) begin
        rgb_p1 <= {red, green, blue};
        rgb_p2 <= rgb_p1;
    end

    always_comb begin
        h_lead       = hs_p1 & ~hs_p2;
        h_trail      = ~hs_p1 & hs_p2;
        v_lead       = vs_p1 & ~vs_p2;
        h_per_now    = sat_inc16(hclk);
        line_bad     = (h_per_now != H_PER_EXP) || (h_width != H_SW_EXP);
        line_mis_now = h_lead && !skip_chk && line_bad;
        pix_act      = (line >= V_ACT_LO) && (line < V_ACT_HI) &&
                       (hclk >= H_ACT_LO) && (hclk < H_ACT_HI) &&
                       ((hclk % CPP_W) == 16'd0);
        frame_ok     = !mis_flag && !line_mis_now &&
                       (hedge_cnt == V_TOT_EXP) && (vw_cnt == V_SW_EXP) &&
                       (pix_acc == PIX_EXP);
        timeout      = !h_lead && (hclk >= TO_LAST);
    end

    // Counters and accumulators are aligned with the p2 colour sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hclk      <= 16'd0;
            hw_cnt    <= 16'd0;
            h_width   <= 16'd0;
            h_period  <= 16'd0;
            line      <= 12'd0;
            hedge_cnt <= 12'd0;
            vw_cnt    <= 12'd0;
            pix_acc   <= 20'd0;
            sum_acc   <= 32'd0;
        end else begin
            hclk <= h_lead ? 16'd0 : sat_inc16(hclk);
            if (h_lead)
                hw_cnt <= 16'd1;
            else if (hs_p1)
                hw_cnt <= sat_inc16(hw_cnt);
            if (h_trail)
                h_width <= hw_cnt;
            if (h_lead)
                h_period <= h_per_now;
            if (v_lead)
                line <= 12'd0;
            else if (h_lead)
                line <= sat_inc12(line);
            if (v_lead) begin
                hedge_cnt <= {11'd0, h_lead};
                vw_cnt    <= {11'd0, h_lead};
                pix_acc   <= 20'd0;
                sum_acc   <= 32'd0;
            end else begin
                if (h_lead)
                    hedge_cnt <= sat_inc12(hedge_cnt);
                if (h_lead && vs_p1)
                    vw_cnt <= sat_inc12(vw_cnt);
                if (pix_act) begin
                    pix_acc <= pix_acc + 20'd1;
                    sum_acc <= sum_acc + {20'd0, rgb_p2};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            timing_err <= 1'b0;
            err_cnt    <= 8'd0;
            v_lines    <= 12'd0;
            v_width    <= 12'd0;
            pix_cnt    <= 20'd0;
            frame_sum  <= 32'd0;
            mis_flag   <= 1'b0;
            skip_chk   <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            if (timeout) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                mis_flag <= 1'b0;
                skip_chk <= 1'b1;
            end else begin
                case (state)
                    SEARCH: begin
                        mis_flag <= 1'b0;
                        skip_chk <= 1'b1;
                        if (v_lead)
                            state <= CHECK;
                    end
                    default: begin
                        // The first line measured after acquisition may be partial
                        if (h_lead) begin
                            if (skip_chk)
                                skip_chk <= 1'b0;
                            else if (line_bad)
                                mis_flag <= 1'b1;
                        end
                        if (v_lead) begin
                            frame_done <= 1'b1;
                            v_lines    <= hedge_cnt;
                            v_width    <= vw_cnt;
                            pix_cnt    <= pix_acc;
                            frame_sum  <= sum_acc;
                            mis_flag   <= 1'b0;
                            if (frame_ok) begin
                                state      <= LOCKED;
                                locked     <= 1'b1;
                                timing_err <= 1'b0;
                            end else begin
                                state      <= CHECK;
                                locked     <= 1'b0;
                                timing_err <= 1'b1;
                                err_cnt    <= sat_inc8(err_cnt);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down format
// (8x7 pixels total, 4x3 active, 2 clocks per pixel -> 16 clocks/line, 112 clocks/frame).
module tb_vga_sync_monitor;

    localparam int H_ACTIVE = 4;
    localparam int H_FRONT  = 1;
    localparam int H_SYNC   = 2;
    localparam int H_BACK   = 1;
    localparam int V_ACTIVE = 3;
    localparam int V_FRONT  = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 1;
    localparam int CPP      = 2;

    localparam int LINE_CLK = 16;   // (4+1+2+1)*2
    localparam int HSW_CLK  = 4;    // 2*2
    localparam int V_TOT    = 7;
    localparam int ACT_L0   = 3;    // V_SYNC+V_BACK
    localparam int ACT_L1   = 6;
    localparam int ACT_C0   = 6;    // (H_SYNC+H_BACK)*CPP
    localparam int ACT_C1   = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [11:0] rgb = 12'd0;

    logic        locked, frame_done, timing_err;
    logic [7:0]  err_cnt;
    logic [15:0] h_period, h_width;
    logic [11:0] v_lines, v_width;
    logic [19:0] pix_cnt;
    logic [31:0] frame_sum;

    int vectors = 0;
    int miscompares = 0;
    int fd_count = 0;
    int fd_pos = -1;
    int fd_mark = 0;
    bit inv = 1'b0;
    bit locked_seen = 1'b0;

    logic        s_locked, s_terr;
    logic [7:0]  s_err;
    logic [15:0] s_hper, s_hw;
    logic [11:0] s_vl, s_vw;
    logic [19:0] s_pix;
    logic [31:0] s_sum;

    always #5 clk = ~clk;

    vga_sync_monitor #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .CPP(CPP), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(rgb[11:8]), .green(rgb[7:4]), .blue(rgb[3:0]),
        .locked(locked), .frame_done(frame_done), .timing_err(timing_err),
        .err_cnt(err_cnt), .h_period(h_period), .h_width(h_width),
        .v_lines(v_lines), .v_width(v_width), .pix_cnt(pix_cnt), .frame_sum(frame_sum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic capture(input int pos);
        if (locked === 1'b1)
            locked_seen = 1'b1;
        if (frame_done === 1'b1) begin
            fd_count++;
            fd_pos   = pos;
            s_locked = locked;
            s_terr   = timing_err;
            s_err    = err_cnt;
            s_hper   = h_period;
            s_hw     = h_width;
            s_vl     = v_lines;
            s_vw     = v_width;
            s_pix    = pix_cnt;
            s_sum    = frame_sum;
        end
    endtask

    // Drives lines l0..l1-1; line short_l loses its last two clocks; cst selects F/0/0 colour
    task automatic drive_lines(input int l0, input int l1, input int short_l, input bit cst);
        int len;
        logic [3:0] ln, cn;
        for (int l = l0; l < l1; l++) begin
            len = (l == short_l) ? LINE_CLK - 2 : LINE_CLK;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                capture(l * LINE_CLK + c);
                hsync = (c < HSW_CLK) ^ inv;
                vsync = (l < V_SYNC) ^ inv;
                ln = l[3:0];
                cn = c[3:0];
                if (l >= ACT_L0 && l < ACT_L1 && c >= ACT_C0 && c < ACT_C1)
                    rgb = cst ? 12'hF00 : {ln, cn, 4'h5};
                else
                    rgb = 12'hAAA;
            end
        end
    endtask

    task automatic frame(input int short_l, input bit cst);
        drive_lines(0, V_TOT, short_l, cst);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            capture(-1);
            hsync = 1'b0;
            vsync = 1'b0;
            rgb   = 12'hAAA;
        end
    endtask

    function automatic logic [31:0] any_out();
        return {31'd0, |{locked, frame_done, timing_err, err_cnt, h_period, h_width,
                         v_lines, v_width, pix_cnt, frame_sum}};
    endfunction

    initial begin
        idle(4);
        chk("reset_outputs_zero", any_out(), 0);
        rst = 1'b1;
        idle(2);

        frame(-1, 1'b0);
        chk("no_done_first_frame", 32'(fd_count), 0);
        frame(-1, 1'b0);
        chk("first_done_count", 32'(fd_count), 1);
        chk("done_latency_pos", 32'(fd_pos), 2);
        chk("first_done_locked", 32'(s_locked), 1);

        frame(-1, 1'b1);
        chk("clean_locked", 32'(s_locked), 1);
        chk("clean_h_period", 32'(s_hper), 16);
        chk("clean_h_width", 32'(s_hw), 4);
        chk("clean_v_lines", 32'(s_vl), 7);
        chk("clean_v_width", 32'(s_vw), 2);
        chk("clean_pix_cnt", 32'(s_pix), 12);
        // lines 3..5, clocks 6,8,10,12: 4*(3+4+5)*256 + 3*36*16 + 12*5
        chk("grad_frame_sum", s_sum, 14076);
        chk("clean_timing_err", 32'(s_terr), 0);
        chk("clean_err_cnt", 32'(s_err), 0);

        frame(4, 1'b0);
        chk("const_frame_sum", s_sum, 46080);   // 12 * 0xF00
        chk("const_locked", 32'(s_locked), 1);

        frame(-1, 1'b0);
        chk("short_timing_err", 32'(s_terr), 1);
        chk("short_locked", 32'(s_locked), 0);
        chk("short_err_cnt", 32'(s_err), 1);
        chk("short_pix_cnt", 32'(s_pix), 12);

        frame(-1, 1'b0);
        chk("recover_locked", 32'(s_locked), 1);
        chk("recover_timing_err", 32'(s_terr), 0);
        chk("recover_err_cnt", 32'(s_err), 1);

        fd_mark = fd_count;
        idle(40);
        chk("timeout_locked", 32'(locked), 0);
        chk("timeout_err_cnt", 32'(err_cnt), 1);
        chk("timeout_timing_err", 32'(timing_err), 0);
        frame(-1, 1'b0);
        chk("search_no_done", 32'(fd_count), 32'(fd_mark));
        chk("search_locked", 32'(locked), 0);
        frame(-1, 1'b0);
        chk("relock_done_count", 32'(fd_count), 32'(fd_mark + 1));
        chk("relock_locked", 32'(locked), 1);

        drive_lines(0, 3, -1, 1'b0);
        chk("pre_reset_locked", 32'(locked), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_reset_outputs_zero", any_out(), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        fd_count = 0;
        drive_lines(3, V_TOT, -1, 1'b0);
        chk("post_reset_partial_no_done", 32'(fd_count), 0);
        frame(-1, 1'b0);
        chk("post_reset_first_vsync_no_done", 32'(fd_count), 0);
        frame(-1, 1'b0);
        chk("post_reset_second_vsync_done", 32'(fd_count), 1);
        chk("post_reset_locked", 32'(s_locked), 1);
        chk("post_reset_err_cnt", 32'(s_err), 0);

        @(negedge clk);
        rst = 1'b0;
        inv = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(2);
        locked_seen = 1'b0;
        fd_count = 0;
        repeat (258) frame(-1, 1'b0);
        chk("inv_done_count", 32'(fd_count), 257);
        chk("inv_err_cnt_saturated", 32'(s_err), 255);
        chk("inv_err_cnt_live", 32'(err_cnt), 255);
        chk("inv_timing_err", 32'(s_terr), 1);
        chk("inv_v_width", 32'(s_vw), 5);
        chk("inv_v_lines", 32'(s_vl), 7);
        chk("inv_h_width", 32'(s_hw), 12);
        chk("inv_never_locked", 32'(locked_seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
